// File: rtl/nand_input_debounce.sv
// Input conditioner ahead of the NAND cell: per-channel synchroniser, debounce FSM,
// registered edge pulses and a settled flag.
module nand_input_debounce #(
    parameter int CH          = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [CH-1:0] raw_in,
    output logic [CH-1:0] clean_out,
    output logic [CH-1:0] rise_pulse,
    output logic [CH-1:0] fall_pulse,
    output logic          settled
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    typedef enum logic {
        IDLE,
        COUNT
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q [CH];
    logic [SYNC_STAGES-1:0] sync_d [CH];
    state_e                 state_q [CH];
    state_e                 state_d [CH];
    logic [CW-1:0]          cnt_q [CH];
    logic [CW-1:0]          cnt_d [CH];
    logic [CH-1:0]          clean_q, clean_d;
    logic [CH-1:0]          rise_q, rise_d;
    logic [CH-1:0]          fall_q, fall_d;
    logic                   settled_q, settled_d;
    logic [CH-1:0]          syn;

    for (genvar g = 0; g < CH; g++) begin : g_syn
        assign syn[g] = sync_q[g][SYNC_STAGES-1];
    end

    always_comb begin
        settled_d = 1'b1;
        clean_d   = clean_q;
        rise_d    = '0;
        fall_d    = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            sync_d[i]  = sync_q[i];
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (en) begin
                sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw_in[i]};
                case (state_q[i])
                    IDLE: begin
                        if (syn[i] != clean_q[i]) begin
                            state_d[i] = COUNT;
                            cnt_d[i]   = CW'(1);
                        end
                    end
                    COUNT: begin
                        if (syn[i] == clean_q[i]) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == CNT_MAX) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                            clean_d[i] = syn[i];
                            rise_d[i]  = syn[i];
                            fall_d[i]  = ~syn[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
            // Settled looks ahead at the next synchronised level so a pending change
            // drops the flag on the same edge it reaches the last sync stage.
            if (state_d[i] != IDLE || sync_d[i][SYNC_STAGES-1] != clean_d[i]) begin
                settled_d = 1'b0;
            end
        end
        if (!en) begin
            settled_d = settled_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < CH; i++) begin
                sync_q[i]  <= '0;
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            clean_q   <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            settled_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < CH; i++) begin
                sync_q[i]  <= sync_d[i];
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            clean_q   <= clean_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            settled_q <= settled_d;
        end
    end

    assign clean_out  = clean_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign settled    = settled_q;

endmodule

// File: tb/tb_nand_input_debounce.sv
// Directed bench for nand_input_debounce with default parameters (18-edge latency).
module tb_nand_input_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] raw_in;
    logic [1:0] clean_out;
    logic [1:0] rise_pulse;
    logic [1:0] fall_pulse;
    logic       settled;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic        seen;
    bit          pat [11] = '{1, 0, 1, 1, 0, 1, 0, 1, 1, 1, 0};

    always #5 clk = ~clk;

    nand_input_debounce #(
        .CH          (2),
        .SYNC_STAGES (2),
        .DB_CYCLES   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .raw_in     (raw_in),
        .clean_out  (clean_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .settled    (settled)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // 1: reset with inputs high, then full acceptance
        rst = 1'b1; en = 1'b1; raw_in = 2'b11;
        tick(3);
        chk("rst_clean", 32'(clean_out), 32'h0);
        chk("rst_settled", 32'(settled), 32'h0);
        chk("rst_pulses", 32'({rise_pulse, fall_pulse}), 32'h0);
        rst = 1'b0;
        tick(1);
        chk("t1_settled_e1", 32'(settled), 32'h1);
        tick(1);
        chk("t1_settled_e2", 32'(settled), 32'h0);
        tick(15);
        chk("t1_clean_e17", 32'(clean_out), 32'h0);
        chk("t1_settled_e17", 32'(settled), 32'h0);
        tick(1);
        chk("t1_clean_e18", 32'(clean_out), 32'h3);
        chk("t1_rise_e18", 32'(rise_pulse), 32'h3);
        tick(1);
        chk("t1_rise_e19", 32'(rise_pulse), 32'h0);
        chk("t1_settled_e19", 32'(settled), 32'h1);

        // 2: bring both low, then raise channel 0 alone
        raw_in = 2'b00;
        tick(20);
        chk("t2_clean_low", 32'(clean_out), 32'h0);
        raw_in = 2'b01;
        tick(17);
        chk("t2_clean_e17", 32'(clean_out), 32'h0);
        chk("t2_rise_e17", 32'(rise_pulse), 32'h0);
        tick(1);
        chk("t2_clean_e18", 32'(clean_out), 32'h1);
        chk("t2_rise_e18", 32'(rise_pulse), 32'h1);
        chk("t2_fall_e18", 32'(fall_pulse), 32'h0);
        tick(1);
        chk("t2_rise_e19", 32'(rise_pulse), 32'h0);
        chk("t2_nand_a_only", 32'(~&clean_out), 32'h1);

        // 3: 5-cycle glitch on channel 1 is rejected
        seen = 1'b0;
        raw_in = 2'b11;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            if (clean_out != 2'b01 || rise_pulse != 2'b00 || fall_pulse != 2'b00) seen = 1'b1;
        end
        chk("t3_settled_mid", 32'(settled), 32'h0);
        raw_in = 2'b01;
        for (int k = 0; k < 25; k++) begin
            tick(1);
            if (clean_out != 2'b01 || rise_pulse != 2'b00 || fall_pulse != 2'b00) seen = 1'b1;
        end
        chk("t3_glitch_effect", 32'(seen), 32'h0);
        chk("t3_settled_end", 32'(settled), 32'h1);

        // 4: bounce on channel 1, last low at cycle 10, steady high from 11
        for (int c = 0; c < 11; c++) begin
            raw_in[1] = pat[c];
            tick(1);
        end
        raw_in[1] = 1'b1;
        tick(17);
        chk("t4_clean_e17", 32'(clean_out), 32'h1);
        tick(1);
        chk("t4_clean_e18", 32'(clean_out), 32'h3);
        chk("t4_rise_e18", 32'(rise_pulse), 32'h2);
        chk("t4_nand_both", 32'(~&clean_out), 32'h0);

        // 5: enable dropped for 7 cycles mid-count on channel 0 falling
        raw_in = 2'b10;
        tick(8);
        chk("t5_settled_counting", 32'(settled), 32'h0);
        en = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick(1);
            if (clean_out != 2'b11 || rise_pulse != 2'b00 || fall_pulse != 2'b00) seen = 1'b1;
        end
        chk("t5_frozen", 32'(seen), 32'h0);
        en = 1'b1;
        tick(9);
        chk("t5_clean_e17", 32'(clean_out), 32'h3);
        tick(1);
        chk("t5_clean_e18", 32'(clean_out), 32'h2);
        chk("t5_fall_e18", 32'(fall_pulse), 32'h1);
        tick(1);
        chk("t5_fall_e19", 32'(fall_pulse), 32'h0);

        // 6: reset one edge before channel 0 would accept
        raw_in = 2'b11;
        tick(17);
        chk("t6_clean_pre", 32'(clean_out), 32'h2);
        chk("t6_rise_pre", 32'(rise_pulse), 32'h0);
        rst = 1'b1;
        #1;
        chk("t6_clean_async", 32'(clean_out), 32'h0);
        chk("t6_settled_async", 32'(settled), 32'h0);
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("t6_settled_e1", 32'(settled), 32'h1);
        chk("t6_pulses_e1", 32'({rise_pulse, fall_pulse}), 32'h0);
        chk("t6_clean_e1", 32'(clean_out), 32'h0);
        tick(16);
        chk("t6_clean_e17", 32'(clean_out), 32'h0);
        tick(1);
        chk("t6_clean_e18", 32'(clean_out), 32'h3);
        chk("t6_rise_e18", 32'(rise_pulse), 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
